// File: rtl/sram_port_pkg.sv
// Shared encodings for the dpram port controller: access sizes, FSM states and
// the alignment/size legality rule used at accept time.
package sram_port_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    HOLD = 2'd2
  } state_e;

  // Misaligned halfword/word or the reserved size encoding.
  function automatic logic req_err(input logic [1:0] size, input logic [1:0] lo);
    logic err;
    case (size)
      SIZE_H:  err = lo[0];
      SIZE_W:  err = (lo != 2'b00);
      SIZE_X:  err = 1'b1;
      default: err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/sram_port_ctrl_if.sv
// Request/response handshake between an initiator (LSU or debug bus) and the
// dpram port controller.
interface sram_port_ctrl_if #(
  parameter int unsigned RAM_AW = 11
) ();

  logic              req_vld;
  logic              req_rdy;
  logic              req_we;
  logic [RAM_AW+1:0] req_addr;
  logic [1:0]        req_size;
  logic              req_sext;
  logic [31:0]       req_wdata;
  logic              rsp_vld;
  logic              rsp_rdy;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_vld, req_we, req_addr, req_size, req_sext, req_wdata, rsp_rdy,
    input  req_rdy, rsp_vld, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_vld, req_we, req_addr, req_size, req_sext, req_wdata, rsp_rdy,
    output req_rdy, rsp_vld, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/sram_lane_fmt.sv
// Byte-lane formatting for a 32-bit RAM word: store mask/replication on the
// request side, sub-word extract and sign/zero extension on the response side.
module sram_lane_fmt
  import sram_port_pkg::*;
(
  input  logic [1:0]  wr_size,
  input  logic [1:0]  wr_lo,
  input  logic        wr_we,
  input  logic [31:0] wr_data,
  output logic [3:0]  wem,
  output logic [31:0] din,
  input  logic [1:0]  rd_size,
  input  logic [1:0]  rd_lo,
  input  logic        rd_sext,
  input  logic [31:0] dout,
  output logic [31:0] rdata
);

  logic [31:0] byte_sh;
  logic [31:0] half_sh;

  // Store lanes: replicate data to every lane, the mask selects the live one(s)
  always_comb begin
    wem = 4'b0000;
    din = wr_data;
    case (wr_size)
      SIZE_B: begin
        wem = 4'b0001 << wr_lo;
        din = {4{wr_data[7:0]}};
      end
      SIZE_H: begin
        wem = 4'b0011 << {wr_lo[1], 1'b0};
        din = {2{wr_data[15:0]}};
      end
      SIZE_W:  wem = 4'b1111;
      default: wem = 4'b0000;
    endcase
    if (!wr_we) wem = 4'b0000;
  end

  // Load extract: shift the addressed lane down, then extend to 32 bits
  always_comb begin
    byte_sh = dout >> {rd_lo, 3'b000};
    half_sh = dout >> {rd_lo[1], 4'b0000};
    case (rd_size)
      SIZE_B:  rdata = {{24{rd_sext & byte_sh[7]}}, byte_sh[7:0]};
      SIZE_H:  rdata = {{16{rd_sext & half_sh[15]}}, half_sh[15:0]};
      default: rdata = dout;
    endcase
  end

endmodule

// File: rtl/sram_port_ctrl.sv
// One-port dpram initiator: turns valid/ready byte-addressed load/store requests
// into RAM strobes and returns a valid/ready response one cycle later.
module sram_port_ctrl
  import sram_port_pkg::*;
#(
  parameter int unsigned RAM_AW = 11
) (
  input  logic              clk,
  input  logic              rst,
  sram_port_ctrl_if.slave   bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [3:0]        ram_wem,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_din,
  input  logic [31:0]       ram_dout
);

  state_e      state_q, state_d;
  logic        req_rdy, rsp_vld, accept, err_c;
  logic [31:0] rsp_rdata, fmt_rdata, load_data, hold_q;
  logic [1:0]  lo_q, size_q;
  logic        sext_q, we_q, err_q;

  assign err_c  = req_err(bus.req_size, bus.req_addr[1:0]);
  assign accept = bus.req_vld & req_rdy;

  // Request side is purely combinational so the RAM sees the access in the accept cycle
  assign ram_en   = accept & ~err_c;
  assign ram_we   = bus.req_we;
  assign ram_addr = bus.req_addr[RAM_AW+1:2];

  sram_lane_fmt u_lane_fmt (
    .wr_size (bus.req_size),
    .wr_lo   (bus.req_addr[1:0]),
    .wr_we   (bus.req_we),
    .wr_data (bus.req_wdata),
    .wem     (ram_wem),
    .din     (ram_din),
    .rd_size (size_q),
    .rd_lo   (lo_q),
    .rd_sext (sext_q),
    .dout    (ram_dout),
    .rdata   (fmt_rdata)
  );

  // Stores and rejected requests return zero data
  assign load_data = (we_q | err_q) ? 32'd0 : fmt_rdata;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state: a pending response leaves only when the consumer takes it
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP, HOLD: begin
        if (bus.rsp_rdy) state_d = accept ? RESP : IDLE;
        else             state_d = HOLD;
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs: RESP bypasses RAM data, HOLD replays the captured copy
  always_comb begin
    rsp_vld   = (state_q != IDLE);
    req_rdy   = ~rst & ((state_q == IDLE) | (rsp_vld & bus.rsp_rdy));
    rsp_rdata = 32'd0;
    unique case (state_q)
      RESP:    rsp_rdata = load_data;
      HOLD:    rsp_rdata = hold_q;
      default: rsp_rdata = 32'd0;
    endcase
  end

  assign bus.req_rdy   = req_rdy;
  assign bus.rsp_vld   = rsp_vld;
  assign bus.rsp_rdata = rsp_rdata;
  assign bus.rsp_err   = rsp_vld & err_q;

  // Request attributes captured at accept for formatting the response
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_q   <= 2'b00;
      size_q <= SIZE_B;
      sext_q <= 1'b0;
      we_q   <= 1'b0;
      err_q  <= 1'b0;
    end else if (accept) begin
      lo_q   <= bus.req_addr[1:0];
      size_q <= bus.req_size;
      sext_q <= bus.req_sext;
      we_q   <= bus.req_we;
      err_q  <= err_c;
    end
  end

  // Hold register: freezes the response so later RAM output changes are invisible
  always_ff @(posedge clk) begin
    if (rst)                  hold_q <= 32'd0;
    else if (state_q == RESP) hold_q <= load_data;
  end

endmodule

// File: tb/tb_sram_port_ctrl.sv
// Bench for sram_port_ctrl: directed vector table, hand-written corner
// sequences, and randomized traffic against a byte-array reference model.
module tb_sram_port_ctrl;
  import sram_port_pkg::*;

  localparam int unsigned AW = 11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sram_port_ctrl_if #(.RAM_AW(AW)) bus ();

  logic          ram_en, ram_we;
  logic [3:0]    ram_wem;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_din;
  logic [31:0]   ram_dout;

  sram_port_ctrl #(.RAM_AW(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .ram_en   (ram_en),
    .ram_we   (ram_we),
    .ram_wem  (ram_wem),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .ram_dout (ram_dout)
  );

  // Dual-port RAM model: port A is the DUT, port B is a bench-driven word writer
  logic [31:0]   mem [0:2047];
  logic [AW-1:0] a_addr;
  logic          b_en;
  logic [AW-1:0] b_addr;
  logic [31:0]   b_din;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'd0;
    ram_dout = 32'd0;
    a_addr   = '0;
  end

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        for (int i = 0; i < 4; i++)
          if (ram_wem[i]) mem[ram_addr][8*i +: 8] = ram_din[8*i +: 8];
      end else begin
        ram_dout <= mem[ram_addr];
      end
      a_addr <= ram_addr;
    end
    if (b_en) begin
      mem[b_addr] = b_din;
      if (b_addr == a_addr) ram_dout <= b_din;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic set_req(input logic vld, input logic we, input logic [12:0] addr,
                         input logic [1:0] size, input logic sext, input logic [31:0] wdata);
    bus.req_vld   = vld;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_size  = size;
    bus.req_sext  = sext;
    bus.req_wdata = wdata;
  endtask

  typedef struct {
    logic        we;
    logic [12:0] addr;
    logic [1:0]  size;
    logic        sext;
    logic [31:0] wdata;
    logic        en;
    logic [3:0]  wem;
    logic [31:0] din;
    logic [31:0] rdata;
    logic        err;
  } vec_t;

  function automatic vec_t mk(input logic we, input logic [12:0] addr, input logic [1:0] size,
                              input logic sext, input logic [31:0] wdata, input logic en,
                              input logic [3:0] wem, input logic [31:0] din,
                              input logic [31:0] rdata, input logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.size = size; v.sext = sext; v.wdata = wdata;
    v.en = en; v.wem = wem; v.din = din; v.rdata = rdata; v.err = err;
    return v;
  endfunction

  // Reference model: byte-addressed memory plus at most one outstanding response
  logic [7:0]  ref_mem [0:8191];
  logic        pend;
  logic [31:0] pend_data;
  logic        pend_err;

  // One cycle of model-checked traffic; entered and left at posedge+1
  task automatic model_cycle(input logic vld, input logic we, input logic [12:0] addr,
                             input logic [1:0] size, input logic sext, input logic [31:0] wdata,
                             input logic rdy);
    logic        e, acc;
    int          n, j;
    logic [31:0] v;
    logic [3:0]  wem_e;
    set_req(vld, we, addr, size, sext, wdata);
    bus.rsp_rdy = rdy;
    #4;
    check("m_req_rdy", 32'(bus.req_rdy), 32'(!pend || rdy));
    check("m_rsp_vld", 32'(bus.rsp_vld), 32'(pend));
    if (pend) begin
      check("m_rdata", bus.rsp_rdata, pend_data);
      check("m_err", 32'(bus.rsp_err), 32'(pend_err));
    end
    e   = (size == 2'd3) || (size == 2'd1 && (addr % 2) != 0) || (size == 2'd2 && (addr % 4) != 0);
    acc = vld && (!pend || rdy);
    n   = 1 << size;
    check("m_ram_en", 32'(ram_en), 32'(acc && !e));
    if (acc && !e) begin
      check("m_ram_addr", 32'(ram_addr), 32'(addr / 4));
      check("m_ram_we", 32'(ram_we), 32'(we));
      if (we) begin
        wem_e = 4'b0000;
        for (int k = 0; k < n; k++) wem_e[(int'(addr) + k) % 4] = 1'b1;
        check("m_ram_wem", 32'(ram_wem), 32'(wem_e));
        for (int l = 0; l < 4; l++) begin
          if (wem_e[l]) begin
            j = l - int'(addr % 4);
            check("m_ram_din_lane", 32'(ram_din[8*l +: 8]), 32'(wdata[8*j +: 8]));
          end
        end
        for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
      end
    end
    if (pend && rdy) pend = 1'b0;
    if (acc) begin
      pend     = 1'b1;
      pend_err = e;
      if (we || e) begin
        pend_data = 32'd0;
      end else begin
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(ref_mem[int'(addr) + k]) << (8 * k));
        if (sext && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
        pend_data = v;
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [12];

  initial begin
    for (int i = 0; i < 8192; i++) ref_mem[i] = 8'd0;
    pend = 1'b0; pend_data = 32'd0; pend_err = 1'b0;
    b_en = 1'b0; b_addr = '0; b_din = 32'd0;

    vecs[0]  = mk(1, 13'h10, SIZE_W, 0, 32'hDEADBEEF, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0);
    vecs[1]  = mk(0, 13'h10, SIZE_W, 0, 32'h0, 1, 4'b0000, 32'h0, 32'hDEADBEEF, 0);
    vecs[2]  = mk(1, 13'h13, SIZE_B, 0, 32'h000000A5, 1, 4'b1000, 32'hA5A5A5A5, 32'h0, 0);
    vecs[3]  = mk(0, 13'h13, SIZE_B, 1, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFA5, 0);
    vecs[4]  = mk(0, 13'h13, SIZE_B, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h000000A5, 0);
    vecs[5]  = mk(0, 13'h12, SIZE_H, 1, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFA5AD, 0);
    vecs[6]  = mk(0, 13'h10, SIZE_H, 0, 32'h0, 1, 4'b0000, 32'h0, 32'h0000BEEF, 0);
    vecs[7]  = mk(0, 13'h11, SIZE_B, 1, 32'h0, 1, 4'b0000, 32'h0, 32'hFFFFFFBE, 0);
    vecs[8]  = mk(0, 13'h01, SIZE_H, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
    vecs[9]  = mk(1, 13'h02, SIZE_W, 0, 32'h12345678, 0, 4'b0000, 32'h0, 32'h0, 1);
    vecs[10] = mk(0, 13'h10, SIZE_X, 0, 32'h0, 0, 4'b0000, 32'h0, 32'h0, 1);
    vecs[11] = mk(1, 13'h16, SIZE_H, 0, 32'h00001234, 1, 4'b1100, 32'h12341234, 32'h0, 0);

    // Reset held with a request offered: nothing may be accepted
    rst = 1'b1;
    set_req(1, 0, 13'h0, SIZE_W, 0, 32'h0);
    bus.rsp_rdy = 1'b1;
    repeat (2) begin
      @(negedge clk);
      check("rst_req_rdy", 32'(bus.req_rdy), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_rsp_vld", 32'(bus.rsp_vld), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    #4;
    check("post_rst_req_rdy", 32'(bus.req_rdy), 32'd1);
    check("post_rst_ram_en", 32'(ram_en), 32'd1);
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    #4;
    check("post_rst_rsp_vld", 32'(bus.rsp_vld), 32'd1);
    check("post_rst_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk); #1;

    // Directed vectors, one transaction each with the response taken immediately
    for (int i = 0; i < 12; i++) begin
      set_req(1, vecs[i].we, vecs[i].addr, vecs[i].size, vecs[i].sext, vecs[i].wdata);
      #4;
      check($sformatf("tbl%0d_req_rdy", i), 32'(bus.req_rdy), 32'd1);
      check($sformatf("tbl%0d_ram_en", i), 32'(ram_en), 32'(vecs[i].en));
      if (vecs[i].en) begin
        check($sformatf("tbl%0d_ram_addr", i), 32'(ram_addr), 32'(vecs[i].addr >> 2));
        check($sformatf("tbl%0d_ram_we", i), 32'(ram_we), 32'(vecs[i].we));
        check($sformatf("tbl%0d_ram_wem", i), 32'(ram_wem), 32'(vecs[i].wem));
        if (vecs[i].we) check($sformatf("tbl%0d_ram_din", i), ram_din, vecs[i].din);
      end
      @(posedge clk); #1;
      bus.req_vld = 1'b0;
      #4;
      check($sformatf("tbl%0d_rsp_vld", i), 32'(bus.rsp_vld), 32'd1);
      check($sformatf("tbl%0d_rdata", i), bus.rsp_rdata, vecs[i].rdata);
      check($sformatf("tbl%0d_err", i), 32'(bus.rsp_err), 32'(vecs[i].err));
      @(posedge clk); #1;
    end
    // The halfword store above landed in the upper half of word 5
    set_req(1, 0, 13'h14, SIZE_W, 0, 32'h0);
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    #4;
    check("half_store_readback", bus.rsp_rdata, 32'h12340000);
    @(posedge clk); #1;

    // Backpressure while port B rewrites the word being returned
    set_req(1, 0, 13'h10, SIZE_W, 0, 32'h0);
    bus.rsp_rdy = 1'b0;
    #4;
    check("bp_accept_en", 32'(ram_en), 32'd1);
    @(posedge clk); #1;
    set_req(1, 0, 13'h14, SIZE_W, 0, 32'h0);
    b_en = 1'b1; b_addr = 11'd4; b_din = 32'h11111111;
    #4;
    check("bp_resp_rdata", bus.rsp_rdata, 32'hA5ADBEEF);
    check("bp_resp_req_rdy", 32'(bus.req_rdy), 32'd0);
    check("bp_resp_ram_en", 32'(ram_en), 32'd0);
    @(posedge clk); #1;
    b_en = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #4;
      check("bp_hold_vld", 32'(bus.rsp_vld), 32'd1);
      check("bp_hold_rdata", bus.rsp_rdata, 32'hA5ADBEEF);
      check("bp_hold_req_rdy", 32'(bus.req_rdy), 32'd0);
      check("bp_hold_ram_en", 32'(ram_en), 32'd0);
      check("bp_hold_state", 32'(dut.state_q), 32'(HOLD));
      @(posedge clk); #1;
    end
    set_req(1, 0, 13'h10, SIZE_W, 0, 32'h0);
    bus.rsp_rdy = 1'b1;
    #4;
    check("bp_release_rdata", bus.rsp_rdata, 32'hA5ADBEEF);
    check("bp_release_req_rdy", 32'(bus.req_rdy), 32'd1);
    check("bp_release_ram_en", 32'(ram_en), 32'd1);
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    #4;
    check("bp_next_rdata", bus.rsp_rdata, 32'h11111111);
    @(posedge clk); #1;

    // Reset while a response is pending drops it
    set_req(1, 0, 13'h10, SIZE_W, 0, 32'h0);
    bus.rsp_rdy = 1'b0;
    @(posedge clk); #1;
    bus.req_vld = 1'b0;
    rst = 1'b1;
    #4;
    check("midrst_req_rdy", 32'(bus.req_rdy), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    bus.rsp_rdy = 1'b1;
    #4;
    check("midrst_rsp_vld0", 32'(bus.rsp_vld), 32'd0);
    check("midrst_rdata", bus.rsp_rdata, 32'd0);
    @(posedge clk); #1;
    #4;
    check("midrst_rsp_vld1", 32'(bus.rsp_vld), 32'd0);
    @(posedge clk); #1;

    // Randomized traffic in an untouched region, then a back-to-back load stream
    for (int c = 0; c < 400; c++) begin
      model_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                  13'h100 + 13'($urandom_range(0, 63)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 3) != 0));
    end
    for (int c = 0; c < 8; c++) begin
      model_cycle(1'b1, 1'b0, 13'h100 + 13'(4 * c), SIZE_W, 1'b0, 32'h0, 1'b1);
    end
    for (int c = 0; c < 8; c++) begin
      model_cycle(1'b1, 1'b0, 13'h100 + 13'($urandom_range(0, 63)), 2'($urandom_range(0, 2)),
                  1'($urandom_range(0, 1)), 32'h0, 1'b1);
    end
    for (int c = 0; c < 3; c++) model_cycle(1'b0, 1'b0, 13'h0, SIZE_W, 1'b0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
